// File: rtl/lstm_seq_driver_if.sv
// Sample-in / hidden-state-out streams of the LSTM sequencer.
// Both directions use a valid/ready handshake.
interface lstm_seq_driver_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] x_in;
  logic                  x_valid;
  logic                  x_last;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] h_data;
  logic                  h_valid;
  logic                  h_last;
  logic                  h_ready;

  modport master (
    output x_in,
    output x_valid,
    output x_last,
    input  x_ready,
    input  h_data,
    input  h_valid,
    input  h_last,
    output h_ready
  );

  modport slave (
    input  x_in,
    input  x_valid,
    input  x_last,
    output x_ready,
    output h_data,
    output h_valid,
    output h_last,
    input  h_ready
  );
endinterface

// File: rtl/lstm_seq_driver.sv
// Sequencer around a combinational LSTM cell: feeds X/c/h,
// waits for the cell to settle, captures c/h and emits h.
module lstm_seq_driver #(
  parameter int DATA_WIDTH    = 16,
  parameter int FRACT_WIDTH   = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lstm_seq_driver_if.slave      bus,
  input  logic                  seq_clear,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c,
  output logic [DATA_WIDTH-1:0] cell_h,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic [CNT_WIDTH-1:0]  step_cnt
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..15");
  end

  if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
    $error("FRACT_WIDTH must be below DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_e;

  // The first SETTLE cycle is spent with freshly registered cell inputs,
  // so counting down from SETTLE_CYCLES leaves that many stable cycles.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cell_x_q, cell_x_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] hd_q, hd_d;
  logic                  hl_q, hl_d;
  logic                  last_q, last_d;
  logic [CNT_WIDTH-1:0]  step_q, step_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cell_x_d = cell_x_q;
    c_d      = c_q;
    h_d      = h_q;
    hd_d     = hd_q;
    hl_d     = hl_q;
    last_d   = last_q;
    step_d   = step_q;
    unique case (state_q)
      IDLE: begin
        if (seq_clear) begin
          c_d    = '0;
          h_d    = '0;
          step_d = '0;
        end
        if (bus.x_valid) begin
          cell_x_d = bus.x_in;
          last_d   = bus.x_last;
          cnt_d    = SETTLE_LD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          c_d     = cell_c_out;
          h_d     = cell_h_out;
          hd_d    = cell_h_out;
          hl_d    = last_q;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      EMIT: begin
        if (bus.h_ready) begin
          state_d = IDLE;
          if (hl_q) begin
            c_d    = '0;
            h_d    = '0;
            step_d = '0;
          end else begin
            step_d = step_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cell_x_q <= '0;
      c_q      <= '0;
      h_q      <= '0;
      hd_q     <= '0;
      hl_q     <= 1'b0;
      last_q   <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cell_x_q <= cell_x_d;
      c_q      <= c_d;
      h_q      <= h_d;
      hd_q     <= hd_d;
      hl_q     <= hl_d;
      last_q   <= last_d;
      step_q   <= step_d;
    end
  end

  assign bus.x_ready = (state_q == IDLE);
  assign bus.h_valid = (state_q == EMIT);
  assign bus.h_data  = hd_q;
  assign bus.h_last  = hl_q;
  assign cell_x      = cell_x_q;
  assign cell_c      = c_q;
  assign cell_h      = h_q;
  assign step_cnt    = step_q;

endmodule

// File: tb/tb_lstm_seq_driver.sv
// Bench for lstm_seq_driver: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_lstm_seq_driver;
  localparam int DW = 16;
  localparam int SC = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seq_clear = 1'b0;
  logic [DW-1:0] cell_x, cell_c, cell_h;
  logic [DW-1:0] cell_c_out, cell_h_out;
  logic [CW-1:0] step_cnt;

  int checks = 0;
  int passes = 0;

  lstm_seq_driver_if #(.DATA_WIDTH(DW)) bus ();

  lstm_seq_driver #(
    .DATA_WIDTH(DW), .FRACT_WIDTH(8),
    .SETTLE_CYCLES(SC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst_n), .bus(bus),
    .seq_clear(seq_clear),
    .cell_x(cell_x), .cell_c(cell_c), .cell_h(cell_h),
    .cell_c_out(cell_c_out), .cell_h_out(cell_h_out),
    .step_cnt(step_cnt)
  );

  // stub cell
  assign cell_c_out = cell_x + cell_c;
  assign cell_h_out = cell_h + 16'h0100;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  // ---------------- reference model / per-cycle compare ----------------
  logic [DW-1:0] c_m, h_m, cx_m, hd_m;
  logic [CW-1:0] st_m;
  bit            busy, emit, hl_m, pl_m;
  int            wait_m;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c_m = '0; h_m = '0; cx_m = '0; hd_m = '0; st_m = '0;
        busy = 0; emit = 0; hl_m = 0; pl_m = 0; wait_m = 0;
      end else begin
        chk("x_ready", 32'(bus.x_ready), 32'(!busy));
        chk("h_valid", 32'(bus.h_valid), 32'(emit));
        if (emit) begin
          chk("h_data", 32'(bus.h_data), 32'(hd_m));
          chk("h_last", 32'(bus.h_last), 32'(hl_m));
        end
        chk("cell_x", 32'(cell_x), 32'(cx_m));
        chk("cell_c", 32'(cell_c), 32'(c_m));
        chk("cell_h", 32'(cell_h), 32'(h_m));
        chk("step_cnt", 32'(step_cnt), 32'(st_m));
        if (!busy) begin
          if (seq_clear) begin
            c_m = '0; h_m = '0; st_m = '0;
          end
          if (bus.x_valid) begin
            busy = 1; wait_m = SC + 1;
            cx_m = bus.x_in; pl_m = bus.x_last;
          end
        end else if (!emit) begin
          wait_m--;
          if (wait_m == 0) begin
            hd_m = h_m + 16'h0100;
            c_m  = cx_m + c_m;
            h_m  = hd_m;
            hl_m = pl_m;
            emit = 1;
          end
        end else if (bus.h_ready) begin
          if (hl_m) begin
            c_m = '0; h_m = '0; st_m = '0;
          end else begin
            st_m = st_m + 8'd1;
          end
          busy = 0; emit = 0;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic send(input logic [DW-1:0] x, input bit last,
                      input bit clr);
    bit ok = 0;
    @(posedge clk); #2;
    bus.x_valid = 1'b1; bus.x_in = x;
    bus.x_last = last; seq_clear = clr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.x_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    bus.x_valid = 1'b0; bus.x_last = 1'b0; seq_clear = 1'b0;
  endtask

  task automatic wait_h(input logic [DW-1:0] ed, input bit el,
                        input logic [DW-1:0] ec, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.h_valid) break;
      lat++;
    end
    chk("wait_h_valid", 32'(bus.h_valid), 32'd1);
    chk("d_h_data", 32'(bus.h_data), 32'(ed));
    chk("d_h_last", 32'(bus.h_last), 32'(el));
    chk("d_cell_c", 32'(cell_c), 32'(ec));
    @(posedge clk); #2;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #2; seq_clear = 1'b1;
    @(posedge clk); #2; seq_clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int lat;
  logic [DW-1:0] hold;

  initial begin
    bus.x_in = '0; bus.x_valid = 1'b0;
    bus.x_last = 1'b0; bus.h_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_x_ready", 32'(bus.x_ready), 32'd1);
    chk("rst_h_valid", 32'(bus.h_valid), 32'd0);
    chk("rst_h_data", 32'(bus.h_data), 32'd0);
    chk("rst_step", 32'(step_cnt), 32'd0);
    chk("rst_cell_c", 32'(cell_c), 32'd0);
    rst_n = 1'b1;

    // latency
    send(16'h0100, 0, 0);
    wait_h(16'h0100, 0, 16'h0100, lat);
    chk("latency", 32'(lat), 32'(SC + 1));
    chk("lat_step", 32'(step_cnt), 32'd1);

    clear_pulse();
    chk("clr_step", 32'(step_cnt), 32'd0);
    chk("clr_c", 32'(cell_c), 32'd0);

    // recurrence
    send(16'h0100, 0, 0);
    wait_h(16'h0100, 0, 16'h0100, lat);
    send(16'h0200, 0, 0);
    wait_h(16'h0200, 0, 16'h0300, lat);
    send(16'h0080, 1, 0);
    wait_h(16'h0300, 1, 16'h0380, lat);
    chk("rec_c0", 32'(cell_c), 32'd0);
    chk("rec_h0", 32'(cell_h), 32'd0);
    chk("rec_s0", 32'(step_cnt), 32'd0);

    // backpressure with a pending sample
    bus.h_ready = 1'b0;
    send(16'h0100, 0, 0);
    wait_h(16'h0100, 0, 16'h0100, lat);
    bus.x_valid = 1'b1; bus.x_in = 16'h0200;
    repeat (10) begin
      @(negedge clk);
      chk("bp_h_data", 32'(bus.h_data), 32'h0100);
      chk("bp_x_ready", 32'(bus.x_ready), 32'd0);
    end
    @(posedge clk); #2; bus.h_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_hold", 32'(bus.h_valid), 32'd1);
    @(posedge clk); #2;
    @(negedge clk);
    chk("bp_after_valid", 32'(bus.h_valid), 32'd0);
    chk("bp_after_ready", 32'(bus.x_ready), 32'd1);
    chk("bp_after_step", 32'(step_cnt), 32'd1);
    @(posedge clk); #2; bus.x_valid = 1'b0;
    wait_h(16'h0200, 0, 16'h0300, lat);
    chk("bp_step2", 32'(step_cnt), 32'd2);

    // seq_clear with accepted sample, then during SETTLE
    send(16'h0040, 0, 1);
    wait_h(16'h0100, 0, 16'h0040, lat);
    chk("sc_step", 32'(step_cnt), 32'd1);
    send(16'h0010, 0, 0);
    seq_clear = 1'b1;
    @(posedge clk); #2; seq_clear = 1'b0;
    wait_h(16'h0200, 0, 16'h0050, lat);
    chk("sc_settle_step", 32'(step_cnt), 32'd2);

    // async reset mid-SETTLE
    send(16'h0100, 0, 0);
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    chk("ar_cell_x", 32'(cell_x), 32'd0);
    chk("ar_cell_c", 32'(cell_c), 32'd0);
    chk("ar_step", 32'(step_cnt), 32'd0);
    chk("ar_x_ready", 32'(bus.x_ready), 32'd1);
    @(posedge clk); #3; rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("ar_no_h", 32'(bus.h_valid), 32'd0);
    end
    send(16'h0100, 0, 0);
    wait_h(16'h0100, 0, 16'h0100, lat);

    // step counter wrap
    clear_pulse();
    for (int k = 0; k < 258; k++) begin
      send(16'h0000, 0, 0);
      wait_h(16'((k + 1) * 256), 0, 16'h0000, lat);
      if (k >= 254) chk("wrap_step", 32'(step_cnt), 32'((k + 1) % 256));
    end

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      bus.x_valid = ($urandom_range(0, 2) != 0);
      bus.x_in    = 16'($urandom);
      bus.x_last  = ($urandom_range(0, 3) == 0);
      seq_clear   = ($urandom_range(0, 7) == 0);
      bus.h_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #2;
    bus.x_valid = 1'b0; seq_clear = 1'b0; bus.h_ready = 1'b1;
    repeat (20) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
